// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the inter-FPGA serial link (receiver and transmit shift register).
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; runs every clk.
module sync_2ff
  import serial_frame_rx_pkg::*;
#(
  parameter logic RESET_VAL = IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit 0, WIDTH data bits LSB first, stop bit 1,
// oversampled at CLKS_PER_BIT enabled ticks per bit.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             SI,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic s;

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (SI),
    .q     (s)
  );

  rx_state_t        state, state_n;
  logic [TW-1:0]    tick_cnt, tick_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shreg, shreg_n, data_n;
  logic             armed, armed_n, valid_n, err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      armed      <= armed_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  // Pulses default low every clk so they last one cycle even when enable is low.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    armed_n = armed;
    data_n  = data_out;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (!armed) begin
            if (s == IDLE_LEVEL) armed_n = 1'b1;
          end else if (s == START_BIT) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_M1) begin
            tick_n = '0;
            if (s == START_BIT) begin
              state_n = DATA;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == FULL_M1) begin
            tick_n  = '0;
            shreg_n = {s, shreg[WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) state_n = STOP;
            else                     bit_n   = bit_cnt + BW'(1);
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == FULL_M1) begin
            tick_n  = '0;
            state_n = IDLE;
            if (s == STOP_BIT) begin
              data_n  = shreg;
              valid_n = 1'b1;
            end else begin
              // Line stuck low after a bad stop bit must go high before re-arming.
              err_n   = 1'b1;
              armed_n = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
